mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates a single-port unified memory between the instruction-fetch port and the load/store port of the RISC-V core.
- Serialises accesses with one outstanding transaction.
- Routes each response back to the requester that owns it.
- Sits between the pc/fetch path, the future dmem/load path and the memory model. Replaces separate imem/dmem when the core moves to unified memory.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- MAX_WAIT, 4, consecutive LS grants allowed while IF is pending (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_be  in  DW/8  store byte enables
- ls_gnt  out  1  load/store request accepted (1-cycle pulse)
- ls_rvalid  out  1  load data valid / store complete
- ls_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables (all ones for fetch and loads)
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response valid (also returned for stores)
- mem_rdata  in  DW  memory read data
- arb_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, owner NONE, starvation counter 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is present, select a winner.
  - Latch owner, we, addr, wdata and be into registers.
  - Pulse the winner's gnt combinationally in the same cycle.
  - Next state is REQ. With no request, stay in IDLE.
- Selection: LS wins over IF when both request in the same cycle (the data access belongs to the older instruction).
- REQ:
  - mem_req = 1; mem_we/addr/wdata/be come from the latched registers.
  - Hold until mem_gnt = 1, then go to RESP. There is no timeout.
- RESP:
  - Wait for mem_rvalid.
  - In the mem_rvalid cycle, drive owner_rvalid = 1 and owner_rdata = mem_rdata combinationally.
  - Next state is IDLE.
- Minimum cost is 3 cycles per transaction. Requests are not accepted in REQ or RESP.
- rvalid/rdata for the non-owner stay 0. rdata is 0 whenever rvalid = 0.
- mem_gnt outside REQ and mem_rvalid outside RESP are ignored.
- Latched fields are immune to requester changes after gnt. A requester may drop or change req the cycle after gnt.
- Reset mid-transaction: return to IDLE next cycle and drop the in-flight response; no rvalid is generated.
- A request deasserted before gnt is simply not served (no error).

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro:
  - An up-counter increments on each LS grant made while if_req = 1, saturating at MAX_WAIT.
  - It clears on any IF grant.
  - When the count equals MAX_WAIT and both requesters are present, IF wins the arbitration.
- Without the macro: strict LS priority; the counter logic is absent.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum arb_state_e {IDLE, REQ, RESP}
  - typedef enum arb_owner_e {OWN_NONE, OWN_IF, OWN_LS}
  - width constants ADDR_W = 32 and DATA_W = 32.
- One natural sub-module, mem_arb_select: combinational winner selection plus the starvation counter.
- The FSM and request latches stay in mem_arbiter.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x0000_0010; mem_gnt = 1 at REQ; mem_rvalid at cycle +2 with rdata 0x0050_0093. Expect:
  - if_gnt pulses at cycle 0
  - mem_addr = 0x10, mem_be = 0xF
  - if_rvalid = 1 with if_rdata = 0x0050_0093 at cycle 2
  - ls_rvalid = 0 throughout
- Simultaneous requests: if_req and ls_req both high, ls_addr = 0x100, ls_we = 0. Expect:
  - ls_gnt first; if_gnt on the cycle the arbiter returns to IDLE
  - two complete transactions in 6 cycles with zero-latency memory
- Store: ls_we = 1, ls_addr = 0x200, ls_wdata = 0xDEAD_BEEF, ls_be = 0x3. Expect:
  - mem_we = 1, mem_wdata = 0xDEADBEEF, mem_be = 0x3
  - ls_rvalid pulses on mem_rvalid
- Memory backpressure: hold mem_gnt = 0 for 5 cycles in REQ. Expect:
  - mem_req and all latched fields stable
  - no new gnt issued
  - completion once mem_gnt rises
- Reset in RESP: assert rst for 1 cycle before mem_rvalid. Expect:
  - state IDLE, all outputs 0
  - a late mem_rvalid produces no if_rvalid or ls_rvalid
- MEM_ARB_STARVE_GUARD_EN with MAX_WAIT = 4: ls_req and if_req held high continuously. Expect:
  - 4 LS grants, then 1 IF grant, then the pattern repeats
  - without the macro: IF never granted

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and widths for the unified-memory arbiter
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - fetch vs load/store winner selection (optional MEM_ARB_STARVE_GUARD_EN)
module mem_arb_select
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic if_req,
    input  logic ls_req,
    output logic if_win,
    output logic ls_win
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             starve;

    // Fetch is only promoted once it has watched MAX_WAIT data accesses go first.
    assign starve = (wait_cnt == CNT_W'(MAX_WAIT)) && if_req && ls_req;

    always_comb begin
        if_win = arb_en && if_req && (!ls_req || starve);
        ls_win = arb_en && ls_req && !starve;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (if_win) begin
            wait_cnt <= '0;
        end else if (ls_win && if_req && (wait_cnt != CNT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        if_win = arb_en && if_req && !ls_req;
        ls_win = arb_en && ls_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter of fetch and load/store onto one memory port
// Optional starvation guard for fetch: MEM_ARB_STARVE_GUARD_EN
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW       = ADDR_W,
    parameter int DW       = DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_be,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            arb_busy
);

    arb_state_e       state;
    arb_owner_e       owner_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW/8-1:0]  be_q;

    logic arb_en;
    logic if_win;
    logic ls_win;
    logic resp_hit;

    assign arb_en = (state == IDLE) && !rst;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_win (if_win),
        .ls_win (ls_win)
    );
`else
    logic unused_max_wait;
    assign unused_max_wait = |MAX_WAIT;

    mem_arb_select u_select (
        .arb_en (arb_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_win (if_win),
        .ls_win (ls_win)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ls_win) begin
                        state   <= REQ;
                        owner_q <= OWN_LS;
                        we_q    <= ls_we;
                        addr_q  <= ls_addr;
                        wdata_q <= ls_we ? ls_wdata : '0;
                        be_q    <= ls_we ? ls_be : '1;
                    end else if (if_win) begin
                        state   <= REQ;
                        owner_q <= OWN_IF;
                        we_q    <= 1'b0;
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        be_q    <= '1;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state   <= IDLE;
                        owner_q <= OWN_NONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign if_gnt = if_win;
    assign ls_gnt = ls_win;

    // A response arriving while reset is asserted belongs to an abandoned transaction.
    assign resp_hit  = (state == RESP) && mem_rvalid && !rst;
    assign if_rvalid = resp_hit && (owner_q == OWN_IF);
    assign ls_rvalid = resp_hit && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_be    = mem_req ? be_q : '0;
    assign arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic if_pend;
    logic ls_pend;
    logic exp_if;
    int   grants;

    initial begin
        rst        = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = 32'h0;
        ls_wdata   = 32'h0;
        ls_be      = 4'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // reset state, with a fetch request present that must not be granted
        repeat (2) cyc();
        smp();
        check("rst_if_gnt", if_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        cyc();
        rst    = 1'b0;
        if_req = 1'b0;
        smp();
        check("rst_idle_busy", arb_busy, 0);

        // fetch only; stray mem_gnt/mem_rvalid in IDLE are ignored
        cyc();
        if_req = 1'b1; if_addr = 32'h10; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        smp();
        check("f_if_gnt", if_gnt, 1);
        check("f_ls_gnt", ls_gnt, 0);
        check("f_idle_rvalid", if_rvalid, 0);
        check("f_idle_mem_req", mem_req, 0);
        cyc();
        if_req = 1'b0; if_addr = 32'hFFFF; mem_gnt = 1'b1; mem_rvalid = 1'b0;
        smp();
        check("f_mem_req", mem_req, 1);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_mem_be", mem_be, 4'hF);
        check("f_mem_we", mem_we, 0);
        check("f_no_gnt", if_gnt, 0);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        smp();
        check("f_if_rvalid", if_rvalid, 1);
        check("f_if_rdata", if_rdata, 32'h0050_0093);
        check("f_ls_rvalid", ls_rvalid, 0);
        check("f_ls_rdata", ls_rdata, 0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        check("f_rvalid_drop", if_rvalid, 0);
        check("f_rdata_zero", if_rdata, 0);
        check("f_busy_end", arb_busy, 0);

        // simultaneous requests with zero-latency memory
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        if_addr = 32'h40; ls_addr = 32'h100; ls_we = 1'b0; ls_be = 4'h3;
        if_pend = 1'b1; ls_pend = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cyc();
            if_req = if_pend; ls_req = ls_pend;
            smp();
            check("sim_ls_gnt", ls_gnt, (c == 0));
            check("sim_if_gnt", if_gnt, (c == 3));
            check("sim_ls_rvalid", ls_rvalid, (c == 2));
            check("sim_if_rvalid", if_rvalid, (c == 5));
            if (c == 1) begin
                check("sim_ls_addr", mem_addr, 32'h100);
                check("sim_load_be", mem_be, 4'hF);
            end
            if (c == 4) check("sim_if_addr", mem_addr, 32'h40);
            if (c == 5) check("sim_if_rdata", if_rdata, 32'hCAFE_0001);
            if (c == 6) check("sim_busy_end", arb_busy, 0);
            if (ls_gnt) ls_pend = 1'b0;
            if (if_gnt) if_pend = 1'b0;
        end
        if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // store; requester changes fields right after gnt
        cyc();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
        smp();
        check("st_ls_gnt", ls_gnt, 1);
        cyc();
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 32'h0; ls_be = 4'hF; mem_gnt = 1'b1;
        smp();
        check("st_mem_we", mem_we, 1);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_mem_be", mem_be, 4'h3);
        check("st_mem_addr", mem_addr, 32'h200);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        smp();
        check("st_ls_rvalid", ls_rvalid, 1);
        check("st_if_rvalid", if_rvalid, 0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        check("st_rvalid_drop", ls_rvalid, 0);

        // memory backpressure: 5 cycles without mem_gnt while both requesters knock
        cyc();
        if_req = 1'b1; if_addr = 32'h80;
        smp();
        check("bp_if_gnt", if_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h90; ls_req = 1'b1; ls_addr = 32'h300 + i;
            smp();
            check("bp_mem_req", mem_req, 1);
            check("bp_mem_addr", mem_addr, 32'h80);
            check("bp_mem_be", mem_be, 4'hF);
            check("bp_no_if_gnt", if_gnt, 0);
            check("bp_no_ls_gnt", ls_gnt, 0);
        end
        cyc();
        if_req = 1'b0; mem_gnt = 1'b1;
        smp();
        check("bp_gnt_addr", mem_addr, 32'h80);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        smp();
        check("bp_if_rvalid", if_rvalid, 1);
        check("bp_if_rdata", if_rdata, 32'h1111_2222);
        check("bp_resp_no_gnt", ls_gnt, 0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        check("bp_ls_gnt", ls_gnt, 1);
        cyc();
        ls_req = 1'b0; mem_gnt = 1'b1;
        smp();
        check("bp_ls_addr", mem_addr, 32'h304);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5;
        smp();
        check("bp_ls_rvalid", ls_rvalid, 1);
        check("bp_ls_rdata", ls_rdata, 32'h5);
        cyc();
        mem_rvalid = 1'b0;

        // reset while waiting in RESP; the late response is dropped
        cyc();
        if_req = 1'b1; if_addr = 32'h20;
        smp();
        check("rr_if_gnt", if_gnt, 1);
        cyc();
        if_req = 1'b0; mem_gnt = 1'b1;
        smp();
        check("rr_mem_req", mem_req, 1);
        cyc();
        mem_gnt = 1'b0; rst = 1'b1;
        smp();
        check("rr_rvalid_in_rst", if_rvalid, 0);
        cyc();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        smp();
        check("rr_busy", arb_busy, 0);
        check("rr_mem_req", mem_req, 0);
        check("rr_mem_addr", mem_addr, 0);
        check("rr_if_rvalid", if_rvalid, 0);
        check("rr_ls_rvalid", ls_rvalid, 0);
        check("rr_if_rdata", if_rdata, 0);
        cyc();
        mem_rvalid = 1'b0;

        // both requesters held high continuously, zero-latency memory
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            smp();
            if (if_gnt || ls_gnt) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                exp_if = ((grants % 5) == 4);
`else
                exp_if = 1'b0;
`endif
                check("sv_if_gnt", if_gnt, exp_if);
                check("sv_ls_gnt", ls_gnt, !exp_if);
                grants++;
            end
            cyc();
        end
        check("sv_grants", grants, 10);
        if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
